// File: rtl/nonogram_pkg.sv
// Shared sizing, types and FIFO word encoding for the nonogram line pipeline.
package nonogram_pkg;

  localparam int SIZE      = 3;
  localparam int MAX_CLUES = (SIZE + 1) / 2;
  localparam int CLUE_W    = $clog2(SIZE + 1);
  localparam int CNT_W     = 7;
  localparam int LINE_W    = $clog2(2 * SIZE) + 1;
  localparam int NCLUE_W   = $clog2(MAX_CLUES + 1);

  typedef logic [SIZE-1:0]   option_t;
  typedef logic [CLUE_W-1:0] clue_t;

  typedef enum logic [1:0] {IDLE, HDR, SCAN, FIN} gen_state_t;

  localparam logic FLAG_HDR = 1'b1;
  localparam logic FLAG_OPT = 1'b0;

  // Header word: line index placed in the low bits of an option-wide word.
  function automatic option_t hdr_word(input logic [LINE_W-1:0] line);
    option_t w;
    w = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (i < LINE_W) w[i] = line[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/line_run_match.sv
// Combinational check that a candidate fill pattern has exactly the clue runs.
module line_run_match
  import nonogram_pkg::*;
(
  input  option_t                       cand,
  input  logic [MAX_CLUES*CLUE_W-1:0]   clues,
  input  logic [NCLUE_W-1:0]            num_clues,
  output logic                          match
);

  clue_t          clue_arr [MAX_CLUES];
  logic [SIZE:0]  ext;

  always_comb begin
    for (int k = 0; k < MAX_CLUES; k++) clue_arr[k] = clues[k*CLUE_W +: CLUE_W];
  end

  assign ext = {1'b0, cand};

  // The zero bit appended above SIZE closes any run touching the top cell.
  always_comb begin
    int  run_cnt;
    int  run_len;
    logic ok;
    ok      = 1'b1;
    run_cnt = 0;
    run_len = 0;
    for (int i = 0; i <= SIZE; i++) begin
      if (ext[i]) begin
        run_len++;
      end else if (run_len != 0) begin
        if (run_cnt >= int'(num_clues)) ok = 1'b0;
        for (int k = 0; k < MAX_CLUES; k++) begin
          if (k == run_cnt && int'(clue_arr[k]) != run_len) ok = 1'b0;
        end
        run_cnt++;
        run_len = 0;
      end
    end
    match = ok && (run_cnt == int'(num_clues));
  end

endmodule

// File: rtl/line_option_gen.sv
// Enumerates every fill pattern of one line that satisfies its clues and
// streams a header word plus the matching options to the option FIFO.
//
// state | meaning
// IDLE  | waiting for start; clues latched on start
// HDR   | presenting the line-index header word
// SCAN  | walking candidates upward, presenting each match
// FIN   | one-cycle done pulse with count and overflow
module line_option_gen
  import nonogram_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LINE_W-1:0]           line_ind,
  input  logic [NCLUE_W-1:0]          num_clues,
  input  logic [MAX_CLUES*CLUE_W-1:0] clues,
  output logic                        out_valid,
  input  logic                        out_ready,
  output option_t                     out_data,
  output logic                        out_is_hdr,
  output logic                        done,
  output logic [CNT_W-1:0]            opt_count,
  output logic                        overflow,
  output logic                        busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  gen_state_t                  state;
  logic [LINE_W-1:0]           line_r;
  logic [NCLUE_W-1:0]          nclue_r;
  logic [MAX_CLUES*CLUE_W-1:0] clues_r;
  logic [SIZE:0]               cand;
  logic [CNT_W-1:0]            count;
  logic                        ovf_r;
  logic                        match;

  line_run_match u_match (
    .cand      (cand[SIZE-1:0]),
    .clues     (clues_r),
    .num_clues (nclue_r),
    .match     (match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      line_r     <= '0;
      nclue_r    <= '0;
      clues_r    <= '0;
      cand       <= '0;
      count      <= '0;
      ovf_r      <= 1'b0;
      out_valid  <= 1'b0;
      out_is_hdr <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
      opt_count  <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            line_r     <= line_ind;
            nclue_r    <= num_clues;
            clues_r    <= clues;
            cand       <= '0;
            count      <= '0;
            ovf_r      <= 1'b0;
            busy       <= 1'b1;
            out_valid  <= 1'b1;
            out_is_hdr <= FLAG_HDR;
            out_data   <= hdr_word(line_ind);
            state      <= HDR;
          end
        end
        HDR: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            out_is_hdr <= FLAG_OPT;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (out_valid && out_ready) begin
            if (count == CNT_MAX) ovf_r <= 1'b1;
            else                  count <= count + CNT_W'(1);
          end
          // Output slot refills in the cycle it drains, so a ready sink sees
          // one candidate per cycle.
          if (!out_valid || out_ready) begin
            if (cand[SIZE]) begin
              out_valid <= 1'b0;
              if (!out_valid) begin
                done      <= 1'b1;
                opt_count <= count;
                overflow  <= ovf_r;
                state     <= FIN;
              end
            end else begin
              out_valid  <= match;
              out_is_hdr <= FLAG_OPT;
              out_data   <= cand[SIZE-1:0];
              cand       <= cand + (SIZE+1)'(1);
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
